// File: rtl/axis_pkt_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axis_pkt_rr_arbiter
//
// Two-input AXI-Stream packet arbiter. One downstream stream is shared
// between two requesters using round-robin at packet granularity. Once an
// input is granted, the grant stays with it from the first beat until its
// tlast beat is accepted, so packets from the two inputs never interleave.
// The output stage is a single register slice, and per-input packet
// counters report how many complete packets each input has forwarded.
//
// Parameters:
//   DW  width of all tdata buses
//   CW  width of the per-input packet counters (wrap silently)
//
// Ports:
//   clk         clock, all logic on the rising edge
//   rst         asynchronous reset, active-low (0 = in reset)
//   s1_tdata    input 1 data
//   s1_tvalid   input 1 valid
//   s1_tlast    input 1 end-of-packet
//   s1_tready   input 1 ready
//   s2_tdata    input 2 data
//   s2_tvalid   input 2 valid
//   s2_tlast    input 2 end-of-packet
//   s2_tready   input 2 ready
//   m_tdata     output data (registered)
//   m_tvalid    output valid (registered)
//   m_tlast     output end-of-packet (registered)
//   m_tready    downstream ready
//   busy        1 while a grant is locked
//   grant_id    current or most recent grant: 0 = s1, 1 = s2
//   s1_pkt_cnt  packets forwarded from s1
//   s2_pkt_cnt  packets forwarded from s2
// ---------------------------------------------------------------------------
module axis_pkt_rr_arbiter #(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s1_tdata,
  input  logic          s1_tvalid,
  input  logic          s1_tlast,
  output logic          s1_tready,
  input  logic [DW-1:0] s2_tdata,
  input  logic          s2_tvalid,
  input  logic          s2_tlast,
  output logic          s2_tready,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  output logic          m_tlast,
  input  logic          m_tready,
  output logic          busy,
  output logic          grant_id,
  output logic [CW-1:0] s1_pkt_cnt,
  output logic [CW-1:0] s2_pkt_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            grant_nxt;
  logic            last_grant;
  logic            last_grant_nxt;

  logic [DW-1:0]   sel_data;
  logic            sel_valid;
  logic            sel_last;
  logic            out_free;
  logic            lock_ready;
  logic            accept;
  logic            pkt_done;

  // Mux of the currently granted input. grant_id is held stable for the
  // whole locked packet, so this mux never switches inside a packet.
  always_comb begin
    sel_data  = grant_id ? s2_tdata  : s1_tdata;
    sel_valid = grant_id ? s2_tvalid : s1_tvalid;
    sel_last  = grant_id ? s2_tlast  : s1_tlast;
  end

  // The output slice can take a new beat when it is empty or being drained
  // this cycle. rst is folded in so both readies drop the moment reset is
  // asserted, without waiting for the state register to settle.
  always_comb begin
    out_free   = ~m_tvalid | m_tready;
    lock_ready = rst & (state == LOCK) & out_free;
    s1_tready  = lock_ready & ~grant_id;
    s2_tready  = lock_ready & grant_id;
    accept     = lock_ready & sel_valid;
    pkt_done   = accept & sel_last;
  end

  // Next-state logic. In IDLE a single requester wins outright; with both
  // requesting, the one that did not have the previous packet wins. The
  // lock is released only by an accepted tlast beat, and a stalled granted
  // input simply keeps the lock.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_id;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (s1_tvalid | s2_tvalid) begin
          state_nxt = LOCK;
          grant_nxt = (s1_tvalid & s2_tvalid) ? ~last_grant : s2_tvalid;
        end
      end
      LOCK: begin
        if (pkt_done) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant_id;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Arbitration state. last_grant resets to s2 so that s1 holds first
  // priority after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      grant_id   <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  assign busy = (state == LOCK);

  // Output register slice. A new beat overwrites the slice directly even
  // while the previous one is being taken, giving full throughput. When the
  // slice drains with nothing new, only valid drops; data and last keep the
  // last forwarded beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
    end else if (accept) begin
      m_tdata  <= sel_data;
      m_tvalid <= 1'b1;
      m_tlast  <= sel_last;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  // Packet counters advance when a tlast beat enters the output slice. A
  // packet cut short by reset never reaches tlast and is never counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_pkt_cnt <= '0;
      s2_pkt_cnt <= '0;
    end else if (pkt_done) begin
      if (grant_id) begin
        s2_pkt_cnt <= s2_pkt_cnt + CW'(1);
      end else begin
        s1_pkt_cnt <= s1_pkt_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axis_pkt_rr_arbiter
//
// Self-checking bench for axis_pkt_rr_arbiter. Two packet sources tag their
// data with the source number in bit 7 and a running sequence number below
// it. A cycle-level behavioural model of the arbiter predicts ready, output
// register, grant and counter values, and a per-source scoreboard checks
// that every output beat is the next unsent beat of its source and that
// packets are never interleaved.
// ---------------------------------------------------------------------------
module tb_axis_pkt_rr_arbiter;

  localparam int DW    = 8;
  localparam int CW    = 2;
  localparam int CMASK = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [DW-1:0] s1_tdata;
  logic          s1_tvalid;
  logic          s1_tlast;
  logic          s1_tready;
  logic [DW-1:0] s2_tdata;
  logic          s2_tvalid;
  logic          s2_tlast;
  logic          s2_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
  logic          busy;
  logic          grant_id;
  logic [CW-1:0] s1_pkt_cnt;
  logic [CW-1:0] s2_pkt_cnt;

  int checks   = 0;
  int failures = 0;

  // source state
  bit   hold  [2];
  int   rem   [2];
  int   seq   [2];
  bit   en    [2];
  bit   pause [2];
  int   plen  [2];
  int   vprob;
  int   mprob;
  logic [8:0] q0 [$];
  logic [8:0] q1 [$];

  // reference model state
  bit         mlock;
  int         mgnt;
  int         mlast;
  bit         mov;
  logic [7:0] mdata;
  bit         mtl;
  int         mcnt [2];

  // scoreboard state
  bit         sb_mid;
  int         sb_src;
  logic [8:0] out_log [$];

  axis_pkt_rr_arbiter #(.DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .s1_tdata   (s1_tdata),
    .s1_tvalid  (s1_tvalid),
    .s1_tlast   (s1_tlast),
    .s1_tready  (s1_tready),
    .s2_tdata   (s2_tdata),
    .s2_tvalid  (s2_tvalid),
    .s2_tlast   (s2_tlast),
    .s2_tready  (s2_tready),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tlast    (m_tlast),
    .m_tready   (m_tready),
    .busy       (busy),
    .grant_id   (grant_id),
    .s1_pkt_cnt (s1_pkt_cnt),
    .s2_pkt_cnt (s2_pkt_cnt)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and on mismatch counts the failure and
  // reports tag, observed and expected values.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mlock   = 1'b0;
    mgnt    = 0;
    mlast   = 1;
    mov     = 1'b0;
    mdata   = 8'h00;
    mtl     = 1'b0;
    mcnt[0] = 0;
    mcnt[1] = 0;
  endtask

  task automatic src_reset();
    for (int i = 0; i < 2; i++) begin
      hold[i] = 1'b0;
      rem[i]  = 0;
    end
    q0.delete();
    q1.delete();
    sb_mid = 1'b0;
  endtask

  // Decide this cycle's source and sink behaviour. A source that raised
  // tvalid keeps it and its data until the beat is taken; a paused source
  // raises nothing new, and a disabled source starts no new packets.
  task automatic drive_inputs();
    for (int i = 0; i < 2; i++) begin
      if (!hold[i] && !pause[i]) begin
        if (rem[i] == 0) begin
          if (en[i] && ($urandom_range(99) < vprob)) begin
            rem[i]  = (plen[i] != 0) ? plen[i] : int'($urandom_range(1, 4));
            hold[i] = 1'b1;
          end
        end else if ($urandom_range(99) < vprob) begin
          hold[i] = 1'b1;
        end
      end
    end
    s1_tvalid = hold[0];
    s1_tdata  = {1'b0, 7'(seq[0])};
    s1_tlast  = (rem[0] == 1);
    s2_tvalid = hold[1];
    s2_tdata  = {1'b1, 7'(seq[1])};
    s2_tlast  = (rem[1] == 1);
    m_tready  = ($urandom_range(99) < mprob);
  endtask

  // One clock cycle: drive, check readies mid-cycle, advance the model and
  // the sources across the edge, then check the registered outputs.
  task automatic applyStimulus();
    bit         v   [2];
    bit         er  [2];
    bit         f   [2];
    logic [7:0] d   [2];
    bit         l   [2];
    bit         mr;
    bit         ofire;
    logic [8:0] obeat;
    logic [8:0] front;
    int         src;

    drive_inputs();
    @(negedge clk);
    v[0] = s1_tvalid;  v[1] = s2_tvalid;
    d[0] = s1_tdata;   d[1] = s2_tdata;
    l[0] = s1_tlast;   l[1] = s2_tlast;
    mr   = m_tready;
    for (int i = 0; i < 2; i++) begin
      er[i] = mlock && (mgnt == i) && (!mov || mr);
    end
    checkOutput("s1_tready", 32'(s1_tready), 32'(er[0]));
    checkOutput("s2_tready", 32'(s2_tready), 32'(er[1]));
    f[0]  = s1_tvalid & s1_tready;
    f[1]  = s2_tvalid & s2_tready;
    ofire = m_tvalid & mr;
    obeat = {m_tlast, m_tdata};

    @(posedge clk);
    #1;

    // model: output slice and packet end, using pre-edge grant state
    if (mlock && er[mgnt] && v[mgnt]) begin
      mov   = 1'b1;
      mdata = d[mgnt];
      mtl   = l[mgnt];
      if (l[mgnt]) begin
        mlock      = 1'b0;
        mlast      = mgnt;
        mcnt[mgnt] = (mcnt[mgnt] + 1) & CMASK;
      end
    end else begin
      if (mr) mov = 1'b0;
      if (!mlock && (v[0] || v[1])) begin
        mlock = 1'b1;
        mgnt  = (v[0] && v[1]) ? (1 - mlast) : (v[1] ? 1 : 0);
      end
    end

    // sources: beats taken by the DUT become owed to the output
    for (int i = 0; i < 2; i++) begin
      if (f[i]) begin
        if (i == 0) q0.push_back({l[i], d[i]});
        else        q1.push_back({l[i], d[i]});
        seq[i]  = seq[i] + 1;
        rem[i]  = rem[i] - 1;
        hold[i] = 1'b0;
      end
    end

    // scoreboard: each output beat must be the oldest owed beat of its source
    if (ofire) begin
      out_log.push_back(obeat);
      src = int'(obeat[7]);
      if (sb_mid) checkOutput("no_interleave", 32'(src), 32'(sb_src));
      if (src == 0) begin
        checkOutput("sb_s1_has_beat", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) begin
          front = q0.pop_front();
          checkOutput("sb_s1_beat", 32'(obeat), 32'(front));
        end
      end else begin
        checkOutput("sb_s2_has_beat", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          front = q1.pop_front();
          checkOutput("sb_s2_beat", 32'(obeat), 32'(front));
        end
      end
      sb_src = src;
      sb_mid = !obeat[8];
    end

    checkOutput("m_tvalid",   32'(m_tvalid),   32'(mov));
    checkOutput("m_tdata",    32'(m_tdata),    32'(mdata));
    checkOutput("m_tlast",    32'(m_tlast),    32'(mtl));
    checkOutput("busy",       32'(busy),       32'(mlock));
    checkOutput("grant_id",   32'(grant_id),   32'(mgnt));
    checkOutput("s1_pkt_cnt", 32'(s1_pkt_cnt), 32'(mcnt[0]));
    checkOutput("s2_pkt_cnt", 32'(s2_pkt_cnt), 32'(mcnt[1]));
  endtask

  // Assert reset asynchronously, check the cleared outputs straight away
  // and again after an edge, then release with both inputs idle.
  task automatic doReset(input bit both_valid);
    rst       = 1'b0;
    s1_tvalid = both_valid;
    s2_tvalid = both_valid;
    m_tready  = 1'b1;
    #1;
    checkOutput("rst_m_tvalid", 32'(m_tvalid),   32'd0);
    checkOutput("rst_m_tdata",  32'(m_tdata),    32'd0);
    checkOutput("rst_m_tlast",  32'(m_tlast),    32'd0);
    checkOutput("rst_busy",     32'(busy),       32'd0);
    checkOutput("rst_grant_id", 32'(grant_id),   32'd0);
    checkOutput("rst_s1_cnt",   32'(s1_pkt_cnt), 32'd0);
    checkOutput("rst_s2_cnt",   32'(s2_pkt_cnt), 32'd0);
    checkOutput("rst_s1_tready", 32'(s1_tready), 32'd0);
    checkOutput("rst_s2_tready", 32'(s2_tready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_s1_tready", 32'(s1_tready), 32'd0);
    checkOutput("rst_hold_s2_tready", 32'(s2_tready), 32'd0);
    checkOutput("rst_hold_busy",      32'(busy),      32'd0);
    s1_tvalid = 1'b0;
    s2_tvalid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    src_reset();
  endtask

  initial begin
    int         n;
    int         k;
    logic [CW-1:0] prev;
    logic [7:0] held;

    rst       = 1'b0;
    s1_tdata  = '0;
    s1_tvalid = 1'b0;
    s1_tlast  = 1'b0;
    s2_tdata  = '0;
    s2_tvalid = 1'b0;
    s2_tlast  = 1'b0;
    m_tready  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      seq[i] = 0; en[i] = 1'b0; pause[i] = 1'b0; plen[i] = 0;
    end
    vprob = 100;
    mprob = 100;
    model_reset();
    src_reset();

    // reset with both inputs requesting, then s1 must win first
    $display("[TB] reset and first grant");
    doReset(1'b1);
    en[0] = 1'b1; en[1] = 1'b1; plen[0] = 3; plen[1] = 3;
    out_log.delete();
    applyStimulus();
    checkOutput("first_grant_s1", 32'(grant_id), 32'd0);
    checkOutput("first_grant_busy", 32'(busy), 32'd1);

    // contention: 3-beat packets alternate s1, s2 with tlast every 3rd beat
    $display("[TB] contention");
    for (int i = 0; i < 24; i++) applyStimulus();
    checkOutput("contention_beats", 32'(out_log.size() >= 12), 32'd1);
    for (int i = 0; i < 12 && i < out_log.size(); i++) begin
      checkOutput("contention_src",  32'(out_log[i][7]), 32'((i / 3) % 2));
      checkOutput("contention_last", 32'(out_log[i][8]), 32'((i % 3) == 2));
    end

    // backpressure mid-packet: output holds, nothing lost after release
    $display("[TB] backpressure");
    doReset(1'b0);
    en[0] = 1'b1; en[1] = 1'b0; plen[0] = 6; vprob = 100; mprob = 100;
    n = 0;
    while (rem[0] != 3 && n < 20) begin applyStimulus(); n++; end
    checkOutput("bp_reach_mid", 32'(rem[0]), 32'd3);
    en[0] = 1'b0;
    mprob = 0;
    applyStimulus();
    held = m_tdata;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      checkOutput("bp_valid_held", 32'(m_tvalid), 32'd1);
      checkOutput("bp_data_held",  32'(m_tdata),  32'(held));
    end
    mprob = 100;
    for (int i = 0; i < 12; i++) applyStimulus();
    checkOutput("bp_drained", 32'(q0.size()), 32'd0);

    // lock hold: s1 stalls after beat 2, s2 must stay blocked until s1 ends
    $display("[TB] lock hold");
    doReset(1'b0);
    en[0] = 1'b1; en[1] = 1'b1; plen[0] = 4; plen[1] = 4;
    n = 0;
    while (rem[0] != 2 && n < 20) begin applyStimulus(); n++; end
    checkOutput("hold_reach_beat2", 32'(rem[0]), 32'd2);
    en[0] = 1'b0;
    pause[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput("hold_s2_blocked", 32'(s2_tready), 32'd0);
      checkOutput("hold_grant_s1",   32'(grant_id),  32'd0);
    end
    pause[0] = 1'b0;
    n = 0;
    while (!(busy && grant_id) && n < 20) begin applyStimulus(); n++; end
    checkOutput("hold_then_s2", 32'(grant_id), 32'd1);
    checkOutput("hold_s1_done", 32'(s1_pkt_cnt), 32'd1);

    // counter wrap with single-beat packets on s2 only
    $display("[TB] counter wrap");
    doReset(1'b0);
    en[0] = 1'b0; en[1] = 1'b1; plen[1] = 1;
    prev = s2_pkt_cnt;
    k = 0;
    n = 0;
    while (k < 5 && n < 40) begin
      applyStimulus();
      n++;
      if (s2_pkt_cnt != prev) begin
        checkOutput("wrap_seq", 32'(s2_pkt_cnt), 32'((k + 1) % 4));
        prev = s2_pkt_cnt;
        k++;
      end
      checkOutput("wrap_s1_zero", 32'(s1_pkt_cnt), 32'd0);
    end
    checkOutput("wrap_count", 32'(k), 32'd5);

    // reset in the middle of a packet, then arbitration restarts with s1
    $display("[TB] mid-packet reset");
    doReset(1'b0);
    en[0] = 1'b1; en[1] = 1'b0; plen[0] = 4;
    n = 0;
    while (rem[0] != 2 && n < 20) begin applyStimulus(); n++; end
    checkOutput("midrst_reach_beat2", 32'(rem[0]), 32'd2);
    doReset(1'b0);
    en[0] = 1'b1; en[1] = 1'b1; plen[0] = 2; plen[1] = 2;
    applyStimulus();
    checkOutput("midrst_regrant_s1", 32'(grant_id), 32'd0);
    checkOutput("midrst_busy",       32'(busy),     32'd1);

    // randomized traffic against the model and scoreboard
    $display("[TB] random traffic");
    plen[0] = 0; plen[1] = 0; vprob = 60; mprob = 70;
    for (int i = 0; i < 800; i++) applyStimulus();
    en[0] = 1'b0; en[1] = 1'b0; vprob = 100; mprob = 100;
    for (int i = 0; i < 40; i++) applyStimulus();
    checkOutput("final_s1_drained", 32'(q0.size()), 32'd0);
    checkOutput("final_s2_drained", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_pkt_rr_arbiter.md
Name: axis_pkt_rr_arbiter

Overview:
Two-input AXI-Stream packet arbiter. It shares one downstream stream between two requesters using round-robin at packet granularity, and locks the grant from the first beat to tlast so packets never interleave. Replaces manual sel-driven muxing in front of shared consumers. The output is registered, and per-input packet counters are provided for status.

Parameters:
DW, 8, data width of all tdata buses
CW, 16, width of per-input packet counters

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset asserted)
s1_tdata  in  DW  input 1 data
s1_tvalid  in  1  input 1 valid
s1_tlast  in  1  input 1 end-of-packet
s1_tready  out  1  input 1 ready
s2_tdata  in  DW  input 2 data
s2_tvalid  in  1  input 2 valid
s2_tlast  in  1  input 2 end-of-packet
s2_tready  out  1  input 2 ready
m_tdata  out  DW  output data (registered)
m_tvalid  out  1  output valid (registered)
m_tlast  out  1  output end-of-packet (registered)
m_tready  in  1  downstream ready
busy  out  1  1 while a grant is locked
grant_id  out  1  current or last grant: 0 = s1, 1 = s2
s1_pkt_cnt  out  CW  packets forwarded from s1
s2_pkt_cnt  out  CW  packets forwarded from s2

Behaviour:
- Reset (rst=0, async):
  - m_tdata=0, m_tvalid=0, m_tlast=0, busy=0, grant_id=0, both counters 0.
  - State IDLE; last_grant=s2, so s1 has first priority.
  - s1_tready=s2_tready=0 combinationally while rst=0.
- States: IDLE, LOCK.
- IDLE:
  - Both s*_tready=0.
  - Only one tvalid=1: grant that input.
  - Both tvalid=1: grant the input not equal to last_grant.
  - On a grant: next cycle state=LOCK, busy=1, grant_id=granted input.
  - No tvalid: stay IDLE.
- LOCK:
  - sX_tready = (grant_id==X) & (~m_tvalid | m_tready). Non-granted ready=0.
  - Beat accepted (granted tvalid & tready): m_tdata/m_tlast load from the granted input next edge; m_tvalid=1.
  - Accepted beat with tlast=1: next state IDLE, busy=0, last_grant=grant_id, granted counter +1.
- Output register:
  - No accept and m_tready=1: m_tvalid→0; m_tdata and m_tlast hold their last values.
  - No accept and m_tready=0: hold everything.
  - Same-cycle m_tready=1 and new accept: output updated with no bubble.
- Latency and throughput:
  - tvalid seen in IDLE at edge t: grant at t+1, first beat accepted in cycle t+1, m_tvalid=1 after edge t+2.
  - One beat per cycle inside a packet.
  - Exactly one arbitration bubble cycle between packets.
- Granted input deasserts tvalid mid-packet: remain in LOCK indefinitely (no timeout); the other input stays stalled.
- Counters wrap 2^CW-1 → 0 silently.
- Single-beat packet (tlast on first beat): LOCK lasts one accepted cycle, then IDLE.
- Reset mid-packet:
  - All state clears immediately; the in-flight partial packet is truncated downstream (no tlast emitted).
  - Counters are not incremented for the truncated packet.
- tdata/tlast are sampled only on accepted beats; their values on non-accepted cycles are don't-care.

Test Plan:
- Reset: hold rst=0 with both tvalid=1 → all outputs 0, both tready=0; release → grant_id=0 (s1 first), s1_tready=1 one cycle later.
- Contention: both inputs offer back-to-back 3-beat packets (s1 data 0x11..0x13, s2 0x21..0x23) with m_tready=1 → output order 11,12,13,21,22,23,11,… with tlast on every 3rd beat and one idle cycle between packets; pkt_cnt increments alternate.
- Backpressure: m_tready=0 for 4 cycles mid-packet → m_tvalid stays 1 and m_tdata is held; granted tready=0; no beats lost or duplicated after release.
- Lock hold: s1 packet of 4 beats with a 3-cycle tvalid gap after beat 2 while s2 is valid → s2_tready stays 0 until s1 tlast is accepted; s2 is granted next.
- Counter wrap: CW=2, send 5 single-beat packets on s2 only → s2_pkt_cnt sequence 1,2,3,0,1; s1_pkt_cnt stays 0.
- Mid-packet reset: assert rst=0 on beat 2 of a 4-beat packet → m_tvalid=0 and busy=0 immediately, counter unchanged; after release, arbitration restarts with s1 priority.
